// File: rtl/inst_mem_responder.sv
// ============================================================================
// Module   : inst_mem_responder
// Purpose  : Loadable instruction memory that answers in-order fetch requests
//            after a fixed latency through a 4-entry response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_responder #(
  parameter int          AW      = 10,
  parameter logic [31:0] BASE    = 32'h80000000,
  parameter int          LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_inst,
  output logic          resp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [32:0] c_SPAN  = 33'd4 << AW;
  localparam logic [32:0] c_BASE  = {1'b0, BASE};

  logic [31:0] r_mem [DEPTH];

  logic [32:0] r_fifo [4];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;

  logic [32:0]   w_off;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_acc_d;
  logic          w_accept;
  logic          w_pop;
  logic          w_push_v;
  logic [31:0]   w_push_d;
  logic          w_push_e;
  logic [2:0]    w_inflight;
  logic [2:0]    w_occ;

  // 33-bit offset so an address below BASE cannot wrap into range.
  assign w_off    = {1'b0, req_addr} - c_BASE;
  assign w_err    = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || (w_off >= c_SPAN);
  assign w_idx    = w_off[AW+1:2];
  assign w_acc_d  = w_err ? 32'h00000000 : r_mem[w_idx];

  assign w_occ     = w_inflight + r_count;
  assign req_ready = rst && (w_occ < 3'd4);
  assign w_accept  = req_valid && req_ready;

  assign resp_valid = (r_count != 3'd0);
  assign w_pop      = resp_valid && resp_ready;
  assign resp_inst  = resp_valid ? r_fifo[r_rptr][31:0] : 32'h00000000;
  assign resp_err   = resp_valid ? r_fifo[r_rptr][32]   : 1'b0;

  // Load path; the read above sees the old word on a same-edge write.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  generate
    if (LATENCY <= 1) begin : g_lat1
      assign w_push_v   = w_accept;
      assign w_push_d   = w_acc_d;
      assign w_push_e   = w_err;
      assign w_inflight = 3'd0;
    end else begin : g_latn
      localparam int STAGES = LATENCY - 1;

      logic [STAGES-1:0] r_pv;
      logic [STAGES-1:0] r_pe;
      logic [31:0]       r_pd [STAGES];
      logic [2:0]        r_inflight;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_pv       <= '0;
          r_pe       <= '0;
          r_inflight <= 3'd0;
          for (int i = 0; i < STAGES; i++) begin
            r_pd[i] <= 32'h00000000;
          end
        end else begin
          r_pv[0] <= w_accept;
          r_pe[0] <= w_err;
          r_pd[0] <= w_acc_d;
          for (int i = 1; i < STAGES; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pe[i] <= r_pe[i-1];
            r_pd[i] <= r_pd[i-1];
          end
          r_inflight <= r_inflight + {2'b00, w_accept} - {2'b00, r_pv[STAGES-1]};
        end
      end

      assign w_push_v   = r_pv[STAGES-1];
      assign w_push_d   = r_pd[STAGES-1];
      assign w_push_e   = r_pe[STAGES-1];
      assign w_inflight = r_inflight;
    end
  endgenerate

  // Admission control guarantees a free slot for every push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push_v) begin
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      r_count <= r_count + {2'b00, w_push_v} - {2'b00, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_v) begin
      r_fifo[r_wptr] <= {w_push_e, w_push_d};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_responder.sv
// ============================================================================
// Module   : tb_inst_mem_responder
// Purpose  : Directed, scoreboard-checked bench for inst_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_mem_responder;

  localparam int          AW      = 10;
  localparam logic [31:0] BASE    = 32'h80000000;
  localparam int          LATENCY = 2;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_inst;
  logic          resp_err;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  inst_mem_responder #(.AW(AW), .BASE(BASE), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_inst  (resp_inst),
    .resp_err   (resp_err),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n_resp = 0;
  logic [32:0] sb [$];
  logic [31:0] model_mem [1 << AW];
  logic        held_v = 1'b0;
  logic [32:0] held_val;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    if (a[1:0] != 2'b00 || a < BASE || off >= (33'd4 << AW)) return {1'b1, 32'h0};
    return {1'b0, model_mem[off[AW+1:2]]};
  endfunction

  // Monitor: compares every consumed response and checks held responses stay put.
  always @(negedge clk) begin
    if (!rst) begin
      held_v = 1'b0;
    end else if (resp_valid) begin
      if (held_v) chk("hold_stable", {resp_err, resp_inst}, held_val);
      if (resp_ready) begin
        held_v = 1'b0;
        n_resp++;
        if (sb.size() == 0) chk("unexpected_resp", {resp_err, resp_inst}, 33'h1_FFFFFFFF ^ {resp_err, resp_inst});
        else chk("resp", {resp_err, resp_inst}, sb.pop_front());
      end else begin
        held_v   = 1'b1;
        held_val = {resp_err, resp_inst};
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] a);
    logic acc = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back(model(a));
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) chk("issue_timeout", 33'd0, 33'd1);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    model_mem[a] = d;
    #1 ld_en = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", 33'(sb.size()), 33'd0);
  endtask

  int acc_cnt;
  int saved;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {32'h0, req_ready}, 33'd0);
    chk("rst_resp", {resp_err, resp_inst}, 33'd0);
    chk("rst_resp_valid", {32'h0, resp_valid}, 33'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {32'h0, req_ready}, 33'd1);
    @(posedge clk); #1;

    load(0, 32'h00500093);
    load(3, 32'h11111111);
    for (int k = 1; k < 16; k++) if (k != 3) load(AW'(k), 32'hA0000000 + 32'(k));
    load(1023, 32'hCAFEF00D);

    // First fetch: latency measured from the accept edge.
    resp_ready = 1'b1;
    issue(32'h80000000);
    @(negedge clk);
    chk("lat_early", {32'h0, resp_valid}, 33'd0);
    @(negedge clk);
    chk("lat_on_time", {32'h0, resp_valid}, 33'd1);
    @(posedge clk); #1;
    drain();

    for (int k = 1; k < 8; k++) issue(BASE + 32'(4 * k));
    issue(32'h80000FFC);
    drain();

    // Backpressure: only four requests fit.
    resp_ready = 1'b0;
    acc_cnt = 0;
    req_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_addr = BASE + 32'(4 * (8 + acc_cnt));
      @(negedge clk);
      if (req_ready) begin
        sb.push_back(model(req_addr));
        acc_cnt++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("accepted_count", 33'(acc_cnt), 33'd4);
    @(negedge clk);
    chk("full_not_ready", {32'h0, req_ready}, 33'd0);
    saved = n_resp;
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ready_after_pop", {32'h0, req_ready}, 33'd1);
    @(posedge clk); #1;
    drain();
    chk("drained_count", 33'(n_resp - saved), 33'd4);
    @(negedge clk);
    chk("ready_after_drain", {32'h0, req_ready}, 33'd1);
    @(posedge clk); #1;

    issue(32'h80000002);
    issue(32'h7FFFFFFC);
    issue(32'h80001000);
    drain();

    // Same-edge load and read of word 3 returns the old word.
    ld_en = 1'b1; ld_addr = 3; ld_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 32'h8000000C;
    @(negedge clk);
    chk("ready_for_collision", {32'h0, req_ready}, 33'd1);
    sb.push_back({1'b0, 32'h11111111});
    @(posedge clk);
    model_mem[3] = 32'hDEADBEEF;
    #1 ld_en = 1'b0; req_valid = 1'b0;
    issue(32'h8000000C);
    drain();

    // Reset with three requests outstanding.
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) issue(BASE + 32'(4 * k));
    @(negedge clk);
    chk("pre_rst_valid", {32'h0, resp_valid}, 33'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", {32'h0, resp_valid}, 33'd0);
    chk("async_rst_ready", {32'h0, req_ready}, 33'd0);
    chk("async_rst_resp", {resp_err, resp_inst}, 33'd0);
    sb.delete();
    saved = n_resp;
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {32'h0, req_ready}, 33'd1);
    resp_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_stale_resp", 33'(n_resp - saved), 33'd0);
    @(posedge clk); #1;
    issue(32'h80000000);
    drain();
    chk("word0_survives", 33'(n_resp - saved), 33'd1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
